// File: rtl/nco_tuning_word_estimator.sv
// rtl/nco_tuning_word_estimator.sv - measures sig_in frequency and returns the matching NCO tuning word
// Optional feature macro: NCO_EST_CONTINUOUS_EN (back-to-back measurements after a single start)
module nco_tuning_word_estimator #(
  parameter int width       = 26,
  parameter int periods     = 4,
  parameter int count_width = 24,
  parameter int sync_stages = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [width-1:0] increment,
  output logic             timeout
);

  // Edge counter width, quotient/dividend width, remainder-compare width, step counter width
  localparam int EW = $clog2(periods + 1);
  localparam int QW = width + EW;
  localparam int RW = count_width + 1;
  localparam int SW = $clog2(QW + 1);

  // Dividend periods * 2^width; fits in QW bits because periods < 2^EW
  localparam logic [QW-1:0]          NUM     = {EW'(periods), {width{1'b0}}};
  localparam logic [count_width-1:0] CNT_MAX = {count_width{1'b1}};
  localparam logic [EW-1:0]          EC_LAST = EW'(periods - 1);
  localparam logic [SW-1:0]          STEP_LAST = SW'(QW - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    COUNT,
    DIVIDE,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [sync_stages-1:0] sync_q;
  logic                   sync_dly_q;
  logic                   sig_edge;
  logic [count_width-1:0] cnt_q, cnt_d;
  logic [EW-1:0]          ecnt_q, ecnt_d;
  logic [count_width-1:0] den_q, den_d;
  logic [QW-1:0]          num_q, num_d;
  logic [count_width-1:0] rem_q, rem_d;
  logic [SW-1:0]          step_q, step_d;
  logic [width-1:0]       inc_q, inc_d;
  logic                   tmo_q, tmo_d;
  logic                   valid_q, valid_d;

  // Restoring-division step: the dividend register shifts left and collects quotient bits at its LSB
  logic [RW-1:0]          rem_shift;
  logic                   fits;
  logic [count_width-1:0] rem_diff;
  logic [count_width-1:0] rem_next;
  logic [QW-1:0]          num_next;
  logic [width-1:0]       quo_sat;

  // Synchronizer chain plus one-cycle delay of the last stage for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[sync_stages-2:0], sig_in};
      sync_dly_q <= sync_q[sync_stages-1];
    end
  end

  assign sig_edge = sync_q[sync_stages-1] & ~sync_dly_q;

  // One divider step; the true difference is below the divisor so it fits in count_width bits
  always_comb begin
    rem_shift = {rem_q, num_q[QW-1]};
    fits      = (rem_shift >= {1'b0, den_q});
    rem_diff  = rem_shift[count_width-1:0] - den_q;
    rem_next  = fits ? rem_diff : rem_shift[count_width-1:0];
    num_next  = {num_q[QW-2:0], fits};
    quo_sat   = (|num_next[QW-1:width]) ? {width{1'b1}} : num_next[width-1:0];
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      den_q   <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      step_q  <= '0;
      inc_q   <= '0;
      tmo_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
      den_q   <= den_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      inc_q   <= inc_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic; saturation of the counter wins over a coincident edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ecnt_d  = ecnt_q;
    den_d   = den_q;
    num_d   = num_q;
    rem_d   = rem_q;
    step_d  = step_q;
    inc_d   = inc_q;
    tmo_d   = tmo_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      ARM: begin
        cnt_d = cnt_q + count_width'(1);
        if (cnt_q == CNT_MAX) begin
          state_d = DONE;
          tmo_d   = 1'b1;
          inc_d   = '0;
          valid_d = 1'b1;
        end else if (sig_edge) begin
          state_d = COUNT;
          cnt_d   = '0;
          ecnt_d  = '0;
        end
      end
      COUNT: begin
        cnt_d = cnt_q + count_width'(1);
        if (cnt_q == CNT_MAX) begin
          state_d = DONE;
          tmo_d   = 1'b1;
          inc_d   = '0;
          valid_d = 1'b1;
        end else if (sig_edge) begin
          ecnt_d = ecnt_q + EW'(1);
          if (ecnt_q == EC_LAST) begin
            state_d = DIVIDE;
            den_d   = cnt_q + count_width'(1);
            num_d   = NUM;
            rem_d   = '0;
            step_d  = '0;
          end
        end
      end
      DIVIDE: begin
        num_d  = num_next;
        rem_d  = rem_next;
        step_d = step_q + SW'(1);
        if (step_q == STEP_LAST) begin
          state_d = DONE;
          inc_d   = quo_sat;
          tmo_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      DONE: begin
`ifdef NCO_EST_CONTINUOUS_EN
        state_d = ARM;
        cnt_d   = '0;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign valid     = valid_q;
  assign increment = inc_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_nco_tuning_word_estimator.sv
// tb/tb_nco_tuning_word_estimator.sv - scoreboard bench for nco_tuning_word_estimator
module tb_nco_tuning_word_estimator;

  localparam int W   = 26;
  localparam int P   = 4;
  localparam int CW  = 24;
  localparam int CWT = 8;
  localparam int SS  = 2;
  localparam int Q   = 29;
  localparam int LAT = SS + Q;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a_n, sig_a, start_a, busy_a, valid_a, tmo_a;
  logic [W-1:0] inc_a;
  logic         rst_b_n, sig_b, start_b, busy_b, valid_b, tmo_b;
  logic [W-1:0] inc_b;

  nco_tuning_word_estimator #(
    .width(W), .periods(P), .count_width(CW), .sync_stages(SS)
  ) dut_a (
    .clk(clk), .reset_n(rst_a_n), .sig_in(sig_a), .start(start_a),
    .busy(busy_a), .valid(valid_a), .increment(inc_a), .timeout(tmo_a)
  );

  nco_tuning_word_estimator #(
    .width(W), .periods(P), .count_width(CWT), .sync_stages(SS)
  ) dut_b (
    .clk(clk), .reset_n(rst_b_n), .sig_in(sig_b), .start(start_b),
    .busy(busy_b), .valid(valid_b), .increment(inc_b), .timeout(tmo_b)
  );

  typedef struct {
    logic [W-1:0] inc;
    logic         tmo;
    bit           dc;
    int           at;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t mon_a_e;
  exp_t mon_b_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid_a: increment=%0d timeout=%0b, required no valid", inc_a, tmo_a);
      end else begin
        mon_a_e = exp_a.pop_front();
        if (mon_a_e.dc) begin
          if (tmo_a !== 1'b0) begin
            errors++;
            $display("FAIL result_a_timeout: got %0b, required 0", tmo_a);
          end
        end else if (inc_a !== mon_a_e.inc || tmo_a !== mon_a_e.tmo) begin
          errors++;
          $display("FAIL result_a: increment=%0d timeout=%0b, required %0d/%0b", inc_a, tmo_a, mon_a_e.inc, mon_a_e.tmo);
        end
        if (mon_a_e.at >= 0) begin
          checks++;
          if (cyc !== mon_a_e.at) begin
            errors++;
            $display("FAIL latency_a: valid at cycle %0d, required %0d", cyc, mon_a_e.at);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (valid_b === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid_b: increment=%0d timeout=%0b, required no valid", inc_b, tmo_b);
      end else begin
        mon_b_e = exp_b.pop_front();
        if (inc_b !== mon_b_e.inc || tmo_b !== mon_b_e.tmo) begin
          errors++;
          $display("FAIL result_b: increment=%0d timeout=%0b, required %0d/%0b", inc_b, tmo_b, mon_b_e.inc, mon_b_e.tmo);
        end
        if (mon_b_e.at >= 0) begin
          checks++;
          if (cyc !== mon_b_e.at) begin
            errors++;
            $display("FAIL latency_b: valid at cycle %0d, required %0d", cyc, mon_b_e.at);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_a_n = 1'b0;
    start_a = 1'b0;
    sig_a   = 1'b0;
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic drive_periods(input int per, input int nrise, input bit poke, output int last);
    last = 0;
    for (int r = 0; r < nrise; r++) begin
      @(negedge clk);
      sig_a = 1'b1;
      last  = cyc + 1;
      for (int k = 1; k < per; k++) begin
        @(negedge clk);
        if (k == per / 2) sig_a = 1'b0;
        start_a = poke && (k == per / 2 + 1);
      end
    end
    @(negedge clk);
    start_a = 1'b0;
    sig_a   = 1'b0;
  endtask

  task automatic drain_a(input int limit, input string name);
    int n = 0;
    while (exp_a.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_a.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: %0d results still pending after %0d cycles, required 0", name, exp_a.size(), limit);
      exp_a.delete();
    end
  endtask

  task automatic push_a(input logic [W-1:0] inc, input int at);
    exp_t e;
    e.inc = inc;
    e.tmo = 1'b0;
    e.dc  = 1'b0;
    e.at  = at;
    exp_a.push_back(e);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, valid_a, tmo_a} !== 3'b000 || inc_a !== '0) begin
      errors++;
      $display("FAIL reset_a: busy=%0b valid=%0b timeout=%0b increment=%0d, required all 0", busy_a, valid_a, tmo_a, inc_a);
    end
    checks++;
    if ({busy_b, valid_b, tmo_b} !== 3'b000 || inc_b !== '0) begin
      errors++;
      $display("FAIL reset_b: busy=%0b valid=%0b timeout=%0b increment=%0d, required all 0", busy_b, valid_b, tmo_b, inc_b);
    end
    rst_a_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic measure(input int per, input logic [W-1:0] want, input string name);
    int last;
    do_reset();
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_idle: got %0b, required 0", name, busy_a);
    end
    pulse_start_a();
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_start: got %0b, required 1", name, busy_a);
    end
    drive_periods(per, P + 1, 1'b0, last);
    push_a(want, last + LAT);
    drain_a(200, name);
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || inc_a !== want) begin
      errors++;
      $display("FAIL %s_hold: valid=%0b increment=%0d, required 0/%0d", name, valid_a, inc_a, want);
    end
`ifndef NCO_EST_CONTINUOUS_EN
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_done: got %0b, required 0", name, busy_a);
    end
`endif
  endtask

  task automatic test_basic();
    measure(10, 26'd6710886, "basic");
  endtask

  task automatic test_non_integer();
    measure(7, 26'd9586980, "ratio7");
  endtask

  task automatic test_min_period();
    measure(2, 26'd33554432, "period2");
  endtask

  task automatic test_timeout();
    exp_t e;
    int n = 0;
    @(negedge clk);
    rst_b_n = 1'b1;
    sig_b   = 1'b0;
    repeat (2) @(negedge clk);
    start_b = 1'b1;
    e.inc = '0;
    e.tmo = 1'b1;
    e.dc  = 1'b0;
    e.at  = cyc + 1 + (1 << CWT);
    exp_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    while (exp_b.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_b.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_wait: no valid within 400 cycles, required one");
      exp_b.delete();
    end
    @(negedge clk);
    rst_b_n = 1'b0;
  endtask

  task automatic test_reset_mid();
    int last;
    do_reset();
    pulse_start_a();
    drive_periods(7, P + 1, 1'b0, last);
    push_a(26'd9586980, last + LAT);
    drain_a(200, "pre_mid");
    pulse_start_a();
    drive_periods(10, P + 1, 1'b0, last);
    rst_a_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, valid_a, tmo_a} !== 3'b000 || inc_a !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%0b valid=%0b timeout=%0b increment=%0d, required all 0", busy_a, valid_a, tmo_a, inc_a);
    end
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    repeat (40) @(negedge clk);
    pulse_start_a();
    drive_periods(10, P + 1, 1'b0, last);
    push_a(26'd6710886, last + LAT);
    drain_a(200, "post_mid");
  endtask

  task automatic test_ignored_start();
    int last;
    do_reset();
    pulse_start_a();
    drive_periods(10, P + 1, 1'b1, last);
    push_a(26'd6710886, last + LAT);
    drain_a(200, "ignored_start");
    repeat (150) @(negedge clk);
  endtask

`ifdef NCO_EST_CONTINUOUS_EN
  task automatic test_continuous();
    exp_t e;
    int per, per_next, ph, n, countdown;
    do_reset();
    e.tmo = 1'b0;
    e.at  = -1;
    e.dc  = 1'b0; e.inc = 26'd6710886; exp_a.push_back(e);
    e.dc  = 1'b1; e.inc = '0;          exp_a.push_back(e);
    e.dc  = 1'b0; e.inc = 26'd3355443; exp_a.push_back(e);
    exp_a.push_back(e);
    per = 10; per_next = 10; ph = 0; n = 0; countdown = -1;
    pulse_start_a();
    while (exp_a.size() != 0 && n < 3000) begin
      if (ph == 0) per = per_next;
      sig_a = (ph < per / 2);
      ph = (ph + 1 == per) ? 0 : ph + 1;
      @(negedge clk);
      n++;
      if (countdown < 0 && exp_a.size() == 3) countdown = 12;
      else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) per_next = 20;
      end
    end
    if (exp_a.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL continuous_wait: %0d results pending after 3000 cycles, required 0", exp_a.size());
      exp_a.delete();
    end
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL continuous_busy: got %0b, required 1", busy_a);
    end
    do_reset();
  endtask
`endif

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    sig_a   = 1'b0;
    sig_b   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    test_reset();
    test_basic();
    test_non_integer();
    test_min_period();
    test_timeout();
    test_reset_mid();
    test_ignored_start();
`ifdef NCO_EST_CONTINUOUS_EN
    test_continuous();
`endif
    do_reset();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
